// File: rtl/i2s_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2s_burst_arbiter
// Purpose  : Round-robin burst drain of CH_NUM receiver FIFOs into one
//            valid/ready stream tagged with channel ID and burst-end flag.
//            Optional header word per burst: define I2S_ARB_HEADER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_burst_arbiter #(
  parameter int CH_NUM     = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 87,
  parameter int ID_WIDTH   = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CH_NUM-1:0]            ch_enable,
  input  logic [CH_NUM-1:0]            r_ready,
  output logic [CH_NUM-1:0]            r_enable,
  input  logic [CH_NUM*DATA_WIDTH-1:0] rdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic [ID_WIDTH-1:0]          m_tuser,
  output logic                         m_tlast,
  output logic [15:0]                  burst_cnt
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int ENT_W = DATA_WIDTH + ID_WIDTH + 1;

`ifdef I2S_ARB_HEADER_EN
  typedef enum logic [1:0] {SCAN = 2'd0, BURST = 2'd1, HDR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {SCAN = 2'd0, BURST = 2'd1} state_t;
`endif

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] idx_q, idx_d;
  logic [ID_WIDTH-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  // One-deep pipeline tracking the word that enters the buffer next cycle
  logic                pv_q, pv_d;
  logic                plast_q, plast_d;
  logic [ID_WIDTH-1:0] pgnt_q, pgnt_d;
  logic [ENT_W-1:0]    mem_q [2];
  logic [ENT_W-1:0]    mem_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          occ_q, occ_d;
  logic [15:0]         burst_cnt_q, burst_cnt_d;
`ifdef I2S_ARB_HEADER_EN
  logic                  ph_q, ph_d;
  logic [DATA_WIDTH-1:0] phdr_q, phdr_d;
`endif

  logic                  hit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  pop;
  logic                  credit;
  logic                  issue;
  logic [2:0]            used;

  assign m_tvalid  = (occ_q != 2'd0);
  assign {m_tlast, m_tuser, m_tdata} = m_tvalid ? mem_q[rd_ptr_q] : '0;
  assign burst_cnt = burst_cnt_q;
  assign pop       = m_tvalid & m_tready;
  // A word leaving this cycle frees its slot, which keeps one word per cycle flowing
  assign used      = {1'b0, occ_q} + {2'b00, pv_q} - {2'b00, pop};
  assign credit    = (used < 3'd2);

`ifdef I2S_ARB_HEADER_EN
  assign wr_word = ph_q ? phdr_q : rd_word;
`else
  assign wr_word = rd_word;
`endif

  always_comb begin
    hit      = 1'b0;
    rd_word  = '0;
    r_enable = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (idx_q == ID_WIDTH'(i))  hit = ch_enable[i] & r_ready[i];
      if (pgnt_q == ID_WIDTH'(i)) rd_word = rdata[i*DATA_WIDTH +: DATA_WIDTH];
      r_enable[i] = issue && (gnt_q == ID_WIDTH'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    rd_cnt_d = rd_cnt_q;
    pv_d     = 1'b0;
    plast_d  = 1'b0;
    pgnt_d   = pgnt_q;
    issue    = 1'b0;
`ifdef I2S_ARB_HEADER_EN
    ph_d     = 1'b0;
    phdr_d   = phdr_q;
`endif
    case (state_q)
      SCAN: begin
        if (hit) begin
          gnt_d    = idx_q;
          rd_cnt_d = '0;
`ifdef I2S_ARB_HEADER_EN
          state_d  = HDR;
`else
          state_d  = BURST;
`endif
        end else begin
          idx_d = (idx_q == ID_WIDTH'(CH_NUM - 1)) ? '0 : idx_q + ID_WIDTH'(1);
        end
      end
`ifdef I2S_ARB_HEADER_EN
      HDR: begin
        if (credit) begin
          pv_d    = 1'b1;
          ph_d    = 1'b1;
          pgnt_d  = gnt_q;
          phdr_d  = DATA_WIDTH'({8'hA5, 3'b000, 5'(gnt_q), burst_cnt_q});
          state_d = BURST;
        end
      end
`endif
      BURST: begin
        if (credit) begin
          issue  = 1'b1;
          pv_d   = 1'b1;
          pgnt_d = gnt_q;
          if (rd_cnt_q == CNT_W'(BURST_LEN - 1)) begin
            plast_d = 1'b1;
            state_d = SCAN;
            idx_d   = (gnt_q == ID_WIDTH'(CH_NUM - 1)) ? '0 : gnt_q + ID_WIDTH'(1);
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (pv_q) begin
      mem_d[wr_ptr_q] = {plast_q, pgnt_q, wr_word};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    occ_d       = occ_q + {1'b0, pv_q} - {1'b0, pop};
    burst_cnt_d = burst_cnt_q + {15'd0, pv_q & plast_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      idx_q       <= '0;
      gnt_q       <= '0;
      rd_cnt_q    <= '0;
      pv_q        <= 1'b0;
      plast_q     <= 1'b0;
      pgnt_q      <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      burst_cnt_q <= 16'd0;
`ifdef I2S_ARB_HEADER_EN
      ph_q        <= 1'b0;
      phdr_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      rd_cnt_q    <= rd_cnt_d;
      pv_q        <= pv_d;
      plast_q     <= plast_d;
      pgnt_q      <= pgnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      burst_cnt_q <= burst_cnt_d;
`ifdef I2S_ARB_HEADER_EN
      ph_q        <= ph_d;
      phdr_q      <= phdr_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_burst_arbiter.sv
`default_nettype none
// Directed bench for i2s_burst_arbiter (CH_NUM=4, BURST_LEN=4). Receiver model
// returns {ch[7:0], per-channel read count[23:0]} one cycle after each strobe.
module tb_i2s_burst_arbiter;
  localparam int CH = 4;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int IW = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CH-1:0]    ch_enable = '0;
  logic [CH-1:0]    r_ready = '0;
  logic [CH-1:0]    r_enable;
  logic [CH*DW-1:0] rdata;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic [DW-1:0]    m_tdata;
  logic [IW-1:0]    m_tuser;
  logic             m_tlast;
  logic [15:0]      burst_cnt;

  int total = 0;
  int bad = 0;

  logic [23:0] rx_cnt [CH];
  logic [37:0] cap [$];
  int          str_cnt [CH];
  bit          onehot_bad;

  i2s_burst_arbiter #(.CH_NUM(CH), .DATA_WIDTH(DW), .BURST_LEN(BL), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .ch_enable(ch_enable), .r_ready(r_ready),
    .r_enable(r_enable), .rdata(rdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) rx_cnt[i] <= '0;
      rdata <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (r_enable[i]) begin
          rdata[i*DW +: DW] <= {8'(i), rx_cnt[i]};
          rx_cnt[i]         <= rx_cnt[i] + 24'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cap.delete();
      for (int i = 0; i < CH; i++) str_cnt[i] = 0;
      onehot_bad = 1'b0;
    end else begin
      if (m_tvalid && m_tready) cap.push_back({m_tlast, m_tuser, m_tdata});
      for (int i = 0; i < CH; i++) if (r_enable[i]) str_cnt[i] = str_cnt[i] + 1;
      if ($countones(r_enable) > 1) onehot_bad = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [CH-1:0] en, input logic [CH-1:0] rdy);
    rst_n = 1'b0;
    ch_enable = en;
    r_ready = rdy;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_cap(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (cap.size() >= n) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch_enable = '1;
    r_ready = '0;
    m_tready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (r_enable !== 4'b0) begin bad++; $display("FAIL rst_renable got=%b exp=0", r_enable); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
    total++; if (m_tdata !== 32'h0) begin bad++; $display("FAIL rst_tdata got=%h exp=0", m_tdata); end
    total++; if (m_tuser !== 5'd0) begin bad++; $display("FAIL rst_tuser got=%0d exp=0", m_tuser); end
    total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b exp=0", m_tlast); end
    total++; if (burst_cnt !== 16'd0) begin bad++; $display("FAIL rst_bcnt got=%0d exp=0", burst_cnt); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++; if (r_enable !== 4'b0 || m_tvalid !== 1'b0) begin
      bad++; $display("FAIL idle_scan renable=%b tvalid=%b exp=0/0", r_enable, m_tvalid);
    end
  endtask

`ifndef I2S_ARB_HEADER_EN
  task automatic test_single_channel();
    logic [37:0] exp;
    bit ok;
    do_reset(4'b1111, 4'b0100);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); #1;
      if (r_enable != 4'b0) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL t1_strobe_timeout got=none exp=strobe"); end
    r_ready = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      total++;
      if (r_enable !== ((k < 4) ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL t1_renable[%0d] got=%b exp=%b", k, r_enable, (k < 4) ? 4'b0100 : 4'b0000);
      end
    end
    wait_cap(4, 40, ok);
    repeat (10) @(negedge clk);
    total++; if (cap.size() != 4) begin bad++; $display("FAIL t1_count got=%0d exp=4", cap.size()); end
    for (int k = 0; k < 4 && k < cap.size(); k++) begin
      exp = {(k == 3), 5'd2, 32'h0200_0000 + 32'(k)};
      total++; if (cap[k] !== exp) begin bad++; $display("FAIL t1_word[%0d] got=%h exp=%h", k, cap[k], exp); end
    end
    total++; if (burst_cnt !== 16'd1) begin bad++; $display("FAIL t1_bcnt got=%0d exp=1", burst_cnt); end
  endtask

  task automatic test_mask();
    logic [37:0] exp;
    int b, ch, cnt;
    bit ok;
    do_reset(4'b1101, 4'b1011);
    wait_cap(16, 300, ok);
    r_ready = 4'b0000;
    total++; if (!ok) begin bad++; $display("FAIL t2_timeout got=%0d exp=16 words", cap.size()); end
    for (int k = 0; k < 16 && k < cap.size(); k++) begin
      b = k / 4;
      ch = (b % 2 == 1) ? 3 : 0;
      cnt = (b / 2) * 4 + (k % 4);
      exp = {(k % 4 == 3), 5'(ch), 8'(ch), 24'(cnt)};
      total++; if (cap[k] !== exp) begin bad++; $display("FAIL t2_word[%0d] got=%h exp=%h", k, cap[k], exp); end
    end
    total++; if (str_cnt[1] != 0) begin bad++; $display("FAIL t2_masked_strobes got=%0d exp=0", str_cnt[1]); end
    total++; if (onehot_bad !== 1'b0) begin bad++; $display("FAIL t2_onehot got=%b exp=0", onehot_bad); end
  endtask

  task automatic test_backpressure();
    logic [37:0] exp;
    int stall_str;
    bit ok;
    do_reset(4'b1111, 4'b0001);
    wait_cap(1, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL t3_first_timeout got=none exp=word"); end
    @(posedge clk); #1;
    m_tready = 1'b0;
    r_ready = 4'b0000;
    stall_str = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (r_enable != 4'b0) stall_str++;
      total++;
      if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b0, 5'd0, 32'h0000_0001}) begin
        bad++; $display("FAIL t3_hold[%0d] got=%b_%b_%0d_%h exp=1_0_0_00000001", k, m_tvalid, m_tlast, m_tuser, m_tdata);
      end
    end
    total++; if (stall_str > 2) begin bad++; $display("FAIL t3_outstanding got=%0d exp<=2", stall_str); end
    @(posedge clk); #1 m_tready = 1'b1;
    wait_cap(4, 40, ok);
    repeat (10) @(negedge clk);
    total++; if (cap.size() != 4) begin bad++; $display("FAIL t3_count got=%0d exp=4", cap.size()); end
    for (int k = 0; k < 4 && k < cap.size(); k++) begin
      exp = {(k == 3), 5'd0, 32'(k)};
      total++; if (cap[k] !== exp) begin bad++; $display("FAIL t3_word[%0d] got=%h exp=%h", k, cap[k], exp); end
    end
    total++; if (burst_cnt !== 16'd1) begin bad++; $display("FAIL t3_bcnt got=%0d exp=1", burst_cnt); end
  endtask

  task automatic test_toggle();
    logic [37:0] exp;
    int nlast;
    bit ok;
    do_reset(4'b1111, 4'b0010);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge clk); #1;
      m_tready = ~m_tready;
      if (cap.size() >= 12) ok = 1'b1;
    end
    m_tready = 1'b1;
    total++; if (!ok) begin bad++; $display("FAIL t4_timeout got=%0d exp=12 words", cap.size()); end
    nlast = 0;
    for (int k = 0; k < 12 && k < cap.size(); k++) begin
      exp = {(k % 4 == 3), 5'd1, 32'h0100_0000 + 32'(k)};
      if (cap[k][37]) nlast++;
      total++; if (cap[k] !== exp) begin bad++; $display("FAIL t4_word[%0d] got=%h exp=%h", k, cap[k], exp); end
    end
    total++; if (nlast != 3) begin bad++; $display("FAIL t4_tlast_count got=%0d exp=3", nlast); end
  endtask

  task automatic test_reset_mid_burst();
    int nlast;
    bit ok;
    do_reset(4'b1111, 4'b0100);
    wait_cap(2, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL t5_timeout got=%0d exp=2 words", cap.size()); end
    nlast = 0;
    foreach (cap[k]) if (cap[k][37]) nlast++;
    total++; if (nlast != 0) begin bad++; $display("FAIL t5_early_tlast got=%0d exp=0", nlast); end
    rst_n = 1'b0;
    #1;
    total++; if ({r_enable, m_tvalid, m_tdata, m_tuser, m_tlast, burst_cnt} !== '0) begin
      bad++; $display("FAIL t5_async_clear renable=%b tvalid=%b tdata=%h tuser=%0d tlast=%b bcnt=%0d exp=all0",
                      r_enable, m_tvalid, m_tdata, m_tuser, m_tlast, burst_cnt);
    end
    r_ready = 4'b0101;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    total++; if (burst_cnt !== 16'd0) begin bad++; $display("FAIL t5_bcnt got=%0d exp=0", burst_cnt); end
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); #1;
      if (r_enable != 4'b0) ok = 1'b1;
    end
    total++; if (r_enable !== 4'b0001) begin bad++; $display("FAIL t5_first_grant got=%b exp=0001", r_enable); end
    r_ready = 4'b0000;
    wait_cap(1, 20, ok);
    total++;
    if (!ok || cap[0] !== {1'b0, 5'd0, 32'h0}) begin
      bad++; $display("FAIL t5_first_word got=%h exp=%h", ok ? cap[0] : 38'h0, {1'b0, 5'd0, 32'h0});
    end
  endtask
`endif

`ifdef I2S_ARB_HEADER_EN
  task automatic test_header();
    logic [37:0] exp;
    bit ok;
    do_reset(4'b1111, 4'b1000);
    wait_cap(40, 800, ok);
    r_ready = 4'b0000;
    total++; if (!ok) begin bad++; $display("FAIL t6_timeout got=%0d exp=40 words", cap.size()); end
    if (ok) begin
      total++; if (cap[0] !== {1'b0, 5'd3, 32'hA503_0000}) begin
        bad++; $display("FAIL t6_hdr0 got=%h exp=%h", cap[0], {1'b0, 5'd3, 32'hA503_0000});
      end
      total++; if (cap[35] !== {1'b0, 5'd3, 32'hA503_0007}) begin
        bad++; $display("FAIL t6_hdr7 got=%h exp=%h", cap[35], {1'b0, 5'd3, 32'hA503_0007});
      end
      for (int k = 0; k < 4; k++) begin
        exp = {(k == 3), 5'd3, 32'h0300_001C + 32'(k)};
        total++; if (cap[36+k] !== exp) begin bad++; $display("FAIL t6_data[%0d] got=%h exp=%h", k, cap[36+k], exp); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef I2S_ARB_HEADER_EN
    test_single_channel();
    test_mask();
    test_backpressure();
    test_toggle();
    test_reset_mid_burst();
`else
    test_header();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
